// File: rtl/yildiz_pkg.sv
// Shared types and constants for the yildiz memory arbiter.
// Holds the access FSM encoding, owner codes and default bus widths.
package yildiz_pkg;

  localparam int AW = 12;
  localparam int DW = 16;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/yildiz_rr_pick.sv
// Combinational two-way winner selection between CPU and DMA requesters.
// Ties alternate against the last owner unless a DMA lock is still within budget.
module yildiz_rr_pick
  import yildiz_pkg::*;
(
  input  logic c_req_i,
  input  logic d_req_i,
  input  logic last_owner_i,
  input  logic d_lock_i,
  input  logic lock_at_max_i,
  output logic winner_o
);

  // Select the winning requester for the current IDLE cycle
  always_comb begin
    winner_o = OWN_CPU;
    if (c_req_i && d_req_i) begin
      if ((last_owner_i == OWN_DMA) && d_lock_i && !lock_at_max_i) begin
        winner_o = OWN_DMA;
      end else begin
        winner_o = ~last_owner_i;
      end
    end else if (d_req_i) begin
      winner_o = OWN_DMA;
    end else begin
      winner_o = OWN_CPU;
    end
  end

endmodule

// File: rtl/yildiz_mem_arbiter.sv
// Shares one memory port between the CPU and a DMA requester.
// Every access runs IDLE -> ACCESS -> RESP; mem_* and ack outputs are registered.
module yildiz_mem_arbiter
  import yildiz_pkg::*;
#(
  parameter int AW       = yildiz_pkg::AW,
  parameter int DW       = yildiz_pkg::DW,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  input  logic          d_lock,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  state_e        state_q;
  logic [LW-1:0] lock_cnt_q;
  logic [LW-1:0] lock_cnt_d;
  logic          owner_q;
  logic          acc_we_q;
  logic          mem_we_q;
  logic          c_ack_q;
  logic          d_ack_q;
  logic          busy_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          winner_s;
  logic          lock_at_max_s;

  assign lock_at_max_s = (lock_cnt_q >= LOCK_MAX);

  yildiz_rr_pick u_pick (
    .c_req_i       (c_req),
    .d_req_i       (d_req),
    .last_owner_i  (owner_q),
    .d_lock_i      (d_lock),
    .lock_at_max_i (lock_at_max_s),
    .winner_o      (winner_s)
  );

  // Lock budget after a grant; saturates so a lone locked DMA cannot wrap it
  always_comb begin
    lock_cnt_d = {LW{1'b0}};
    if ((winner_s == OWN_DMA) && d_lock) begin
      if (lock_cnt_q != LOCK_MAX) begin
        lock_cnt_d = lock_cnt_q + LW'(1);
      end else begin
        lock_cnt_d = lock_cnt_q;
      end
    end else begin
      lock_cnt_d = {LW{1'b0}};
    end
  end

  // Access sequencer: grant, latch, drive memory, then acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= {LW{1'b0}};
      owner_q    <= OWN_DMA;
      acc_we_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      c_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= {AW{1'b0}};
      wdata_q    <= {DW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          if (c_req || d_req) begin
            state_q    <= ST_ACCESS;
            busy_q     <= 1'b1;
            owner_q    <= winner_s;
            lock_cnt_q <= lock_cnt_d;
            if (winner_s == OWN_DMA) begin
              addr_q   <= d_addr;
              wdata_q  <= d_wdata;
              acc_we_q <= d_we;
              mem_we_q <= d_we;
            end else begin
              addr_q   <= c_addr;
              wdata_q  <= c_wdata;
              acc_we_q <= c_we;
              mem_we_q <= c_we;
            end
          end else begin
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ST_ACCESS: begin
          state_q  <= ST_RESP;
          mem_we_q <= 1'b0;
          c_ack_q  <= (owner_q == OWN_CPU);
          d_ack_q  <= (owner_q == OWN_DMA);
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_we_q <= 1'b0;
          c_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

  // Read data reaches a requester only during its own read acknowledge
  assign c_rdata = (c_ack_q && !acc_we_q) ? mem_rdata : {DW{1'b0}};
  assign d_rdata = (d_ack_q && !acc_we_q) ? mem_rdata : {DW{1'b0}};

endmodule

// File: doc/yildiz_mem_arbiter.md
# yildiz_mem_arbiter

Two-port memory arbiter that shares the CPU's single memory interface (12-bit address, 16-bit data, write strobe) between the `yildiz_cpu_16bit` core and a DMA/IO requester. It sits between both requesters and the memory, serialises their accesses through a fixed three-state sequence, and applies round-robin arbitration. A bounded DMA lock lets the DMA requester perform short bursts without starving the CPU.

## Interface
- `AW`, 12, address width
- `DW`, 16, data width
- `MAX_LOCK`, 4, max consecutive locked DMA grants while CPU waits (≥1)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `c_req`  in  1  CPU request; held until `c_ack`
- `c_we`  in  1  CPU write (1) / read (0)
- `c_addr`  in  AW  CPU address
- `c_wdata`  in  DW  CPU write data
- `c_ack`  out  1  one-cycle completion pulse to CPU
- `c_rdata`  out  DW  read data, valid with `c_ack`
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_ack`, `d_rdata`  same meanings for the DMA port
- `d_lock`  in  1  DMA requests priority for its next access
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_we`  out  1  memory write strobe
- `mem_rdata`  in  DW  memory read data, one cycle after address
- `owner`  out  1  current or last owner (0 = CPU, 1 = DMA)
- `busy`  out  1  high in ACCESS and RESP

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. The sequence is IDLE → ACCESS → RESP → IDLE, and an access is never aborted.
- IDLE, some req high:
  - Pick a winner.
  - Latch the winner's addr, wdata and we into `mem_*` registers.
  - Set `owner` and go to ACCESS.
- IDLE, no req: stay in IDLE. `mem_we` stays 0.
- ACCESS: `mem_addr`/`mem_wdata` are driven from the latched values. `mem_we` is high for exactly this cycle if the access is a write.
- RESP:
  - Pulse the owner's ack for one cycle.
  - Owner rdata equals `mem_rdata` during the ack. It is 0 for writes and 0 at all other times.
  - Go to IDLE.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both req high: the winner is the port that was not the last owner. The exception is a locked DMA (below).
- Lock:
  - `lock_cnt` increments on each DMA grant made with `d_lock`=1.
  - It clears on any CPU grant, and on a DMA grant with `d_lock`=0.
  - If both request, the last owner was DMA, `d_lock`=1 and `lock_cnt` < `MAX_LOCK`, then DMA wins again.
  - When `lock_cnt` = `MAX_LOCK`, the CPU wins the next tie.
- Requester inputs are sampled only in IDLE.
  - If a requester drops req after being granted, the access still completes and ack still fires.
  - Requesters may change addr/data the cycle after ack.
- The acked requester may keep req high after ack. Its next access is arbitrated in the following IDLE cycle.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE; `lock_cnt`=0.
  - `owner`=1, so the CPU wins the first tie.
  - `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
  - `c_ack`=`d_ack`=0, `c_rdata`=`d_rdata`=0, `busy`=0.
- Latency: req sampled in IDLE at cycle N, memory access at N+1, ack at N+2.
- Throughput: at most one access per 3 cycles.
- Reset asserted mid-access: the access is dropped and no ack is issued. Memory writes are not guaranteed complete if reset lands in ACCESS.
- `c_ack` and `d_ack` are never high in the same cycle.
- `mem_*` outputs are registered. `*_rdata` is a gated combinational path from `mem_rdata`.

## Structure
- Shared package `yildiz_pkg` holds:
  - the state enum (IDLE/ACCESS/RESP)
  - owner constants `OWN_CPU`=0, `OWN_DMA`=1
  - default widths `AW`/`DW`
- Sub-module `yildiz_rr_pick` is the combinational two-way pick. Inputs: `c_req`, `d_req`, `last_owner`, `d_lock`, `lock_at_max`. Output: the winner.
- The FSM, latches and `lock_cnt` stay in the top.

## Test plan
- CPU read only, `c_addr`=0x010, memory returns 0xBEEF:
  - `mem_addr`=0x010 at N+1.
  - `c_ack`=1 with `c_rdata`=0xBEEF at N+2.
  - `d_ack` stays 0.
- DMA write `d_addr`=0xFFF, `d_wdata`=0x1234: `mem_we`=1 for exactly one cycle with those values, then `d_ack` at N+2 with `d_rdata`=0.
- Both requesters hold req continuously, `d_lock`=0, after reset: grants alternate CPU, DMA, CPU, DMA, with an ack every 3 cycles.
- Both request, `d_lock`=1, `MAX_LOCK`=4, DMA won last: 4 consecutive DMA grants, then a CPU grant, then `lock_cnt`=0.
- Back-to-back CPU accesses with req held high: successive `c_ack` pulses exactly 3 cycles apart.
- `rst` pulled low during ACCESS of a DMA write:
  - All outputs return to reset values immediately.
  - No `d_ack`.
  - First tie after release goes to the CPU.
